// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - memory request/response and decoder handshake bundle for instruction_fetch
//
// Purpose: groups the instruction-memory port and the decoder-side output
// port of the fetch unit.
// Signals:
//   imem_req/imem_addr       read request and word-aligned address (fetch -> memory)
//   imem_ready               memory accepts the request this cycle
//   imem_rvalid/rdata/err    read response; err is qualified by rvalid
//   out_valid/out_ready      buffer head handshake toward the decoder
//   out_instr/out_pc         instruction word and its address
//   out_fault                00 none, 01 bus error, 10 misaligned target
// Modports: master = fetch unit, slave = memory plus decoder side.
interface instruction_fetch_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        imem_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [1:0]  out_fault;

   modport master (
      output imem_req, imem_addr,
      input  imem_ready, imem_rvalid, imem_rdata, imem_err,
      output out_valid, out_instr, out_pc, out_fault,
      input  out_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_ready, imem_rvalid, imem_rdata, imem_err,
      input  out_valid, out_instr, out_pc, out_fault,
      output out_ready
   );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with in-order prefetch buffer
//
// Purpose: issues word reads to instruction memory (at most one outstanding),
// stores each returned word with its address and fault code in a small FIFO
// and presents the FIFO head to the decoder. Redirects flush the buffer and
// restart fetch; a response belonging to a request issued before a redirect
// is discarded in DRAIN.
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   en              fetch enable; low stops new requests only
//   redirect_valid  branch/jump/trap redirect, highest priority
//   redirect_pc     redirect target
//   bus (master)    imem_* memory port and out_* decoder port
// FIFO_DEPTH must be 2 or 4 (pointers rely on a power-of-two depth).
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   instruction_fetch_if.master bus
);

   localparam int unsigned   PW      = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int unsigned   CW      = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  fault;
   } entry_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          pend_q, pend_d;
   entry_t        fifo_q [FIFO_DEPTH];
   entry_t        fifo_d [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          pop;
   logic          push;
   logic          outstanding;
   logic [CW-1:0] count_after_pop;
   entry_t        push_entry;
   entry_t        head;

   assign head          = fifo_q[rd_ptr_q];
   assign bus.out_valid = (count_q != '0);
   assign bus.out_instr = bus.out_valid ? head.instr : 32'h0;
   assign bus.out_pc    = bus.out_valid ? head.pc    : 32'h0;
   assign bus.out_fault = bus.out_valid ? head.fault : 2'b00;
   assign bus.imem_req  = (state_q == REQ);
   assign bus.imem_addr = fetch_pc_q;
   assign pop           = bus.out_valid && bus.out_ready;

   always_comb begin
      state_d         = state_q;
      fetch_pc_d      = fetch_pc_q;
      pend_d          = pend_q;
      fifo_d          = fifo_q;
      rd_ptr_d        = rd_ptr_q;
      wr_ptr_d        = wr_ptr_q;
      count_d         = count_q;
      push            = 1'b0;
      push_entry      = '0;
      count_after_pop = count_q - CW'(pop);

      // A response is still owed by memory after this cycle. pend_q covers a
      // request left in flight when a misaligned redirect parked us in HALT.
      outstanding = ((state_q == WAIT)  && !bus.imem_rvalid) ||
                    ((state_q == REQ)   &&  bus.imem_ready)  ||
                    ((state_q == DRAIN) && !bus.imem_rvalid) ||
                    ((state_q == HALT)  &&  pend_q && !bus.imem_rvalid);

      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      if (redirect_valid) begin
         // Flush wins over any same-cycle pop or response.
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         fetch_pc_d = redirect_pc;
         if (redirect_pc[1:0] != 2'b00) begin
            fifo_d[0] = '{pc: redirect_pc, instr: 32'h0, fault: 2'b10};
            wr_ptr_d  = PW'(1);
            count_d   = CW'(1);
            pend_d    = outstanding;
            state_d   = HALT;
         end else begin
            pend_d = 1'b0;
            if (outstanding) begin
               state_d = DRAIN;
            end else if (en) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
      end else begin
         if (pend_q && bus.imem_rvalid) begin
            pend_d = 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (en && (count_after_pop < DEPTH_C)) begin
                  state_d = REQ;
               end
            end
            REQ: begin
               if (bus.imem_ready) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  push = 1'b1;
                  if (bus.imem_err) begin
                     push_entry = '{pc: fetch_pc_q, instr: 32'h0, fault: 2'b01};
                     state_d    = HALT;
                  end else begin
                     push_entry = '{pc: fetch_pc_q, instr: bus.imem_rdata, fault: 2'b00};
                     fetch_pc_d = fetch_pc_q + 32'd4;
                     // The slot just filled counts against the free space.
                     if (en && ((count_after_pop + CW'(1)) < DEPTH_C)) begin
                        state_d = REQ;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
            end
            DRAIN: begin
               if (bus.imem_rvalid) begin
                  if (en && (count_after_pop < DEPTH_C)) begin
                     state_d = REQ;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            HALT: begin
               state_d = HALT;
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // A request is only issued with a slot reserved, so a push never
         // lands on a full buffer.
         if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + PW'(1);
         end
         count_d = count_after_pop + CW'(push);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pend_q     <= 1'b0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         pend_q     <= pend_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         fifo_q     <= fifo_d;
      end
   end

endmodule
